// File: rtl/ltc2308_sample_ctrl_if.sv
// ltc2308_sample_ctrl_if: request, ADC pin and result signals of the LTC2308 sampler (ADC_SAMPLE_CNT_EN adds sample_cnt)
interface ltc2308_sample_ctrl_if;
    logic        start;
    logic        continuous;
    logic [2:0]  ch_sel;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo;
    logic [11:0] data_out;
    logic [2:0]  data_ch;
    logic        data_valid;
    logic        busy;
`ifdef ADC_SAMPLE_CNT_EN
    logic [15:0] sample_cnt;
    modport slave (input start, continuous, ch_sel, adc_sdo,
                   output adc_convst, adc_sck, adc_sdi, data_out, data_ch, data_valid, busy, sample_cnt);
    modport master (output start, continuous, ch_sel, adc_sdo,
                    input adc_convst, adc_sck, adc_sdi, data_out, data_ch, data_valid, busy, sample_cnt);
`else
    modport slave (input start, continuous, ch_sel, adc_sdo,
                   output adc_convst, adc_sck, adc_sdi, data_out, data_ch, data_valid, busy);
    modport master (output start, continuous, ch_sel, adc_sdo,
                    input adc_convst, adc_sck, adc_sdi, data_out, data_ch, data_valid, busy);
`endif
endinterface

// File: rtl/ltc2308_sample_ctrl.sv
// ltc2308_sample_ctrl: LTC2308 convert/SPI sequencer with held result word; ADC_SAMPLE_CNT_EN adds sample_cnt
module ltc2308_sample_ctrl #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input logic                  clk,
    input logic                  reset_n,
    ltc2308_sample_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, XFER, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [5:0]  cfg_q, cfg_d;
    logic [2:0]  cur_ch_q, cur_ch_d, prev_ch_q, prev_ch_d, data_ch_q, data_ch_d;
    logic [11:0] shift_q, shift_d, data_out_q, data_out_d;
    logic        convst_q, convst_d, sck_q, sck_d, sdi_q, sdi_d;
    logic        valid_q, valid_d, busy_q, busy_d;
    logic        launch, conv_end, phase_end, last_fall;

    assign launch    = (state_q == IDLE && bus.start) || (state_q == DONE && bus.continuous);
    assign conv_end  = cnt_q == 16'(CONV_CYCLES - 1);
    assign phase_end = cnt_q == 16'(CLK_DIV - 1);
    assign last_fall = sck_q && phase_end && bit_q == 4'd11;

    // state register
    always_ff @(posedge clk)
        state_q <= !reset_n ? IDLE : state_d;

    // next-state: one pass through convert and transfer per request, chained while continuous
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? CONV : IDLE;
            CONV:    state_d = conv_end ? XFER : CONV;
            XFER:    state_d = last_fall ? DONE : XFER;
            default: state_d = bus.continuous ? CONV : IDLE;
        endcase
    end

    // outputs and datapath: CONVST pulse, SCK phases, SDI/SDO shifting, result hand-off
    always_comb begin
        cnt_d      = cnt_q + 16'd1;
        bit_d      = bit_q;
        cfg_d      = cfg_q;
        cur_ch_d   = cur_ch_q;
        prev_ch_d  = prev_ch_q;
        data_ch_d  = data_ch_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        convst_d   = convst_q;
        sck_d      = sck_q;
        sdi_d      = sdi_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            CONV: begin
                if (cnt_q == 16'd1) convst_d = 1'b0;
                if (conv_end) begin
                    cnt_d = '0;
                    bit_d = '0;
                    sdi_d = cfg_q[5];
                end
            end
            XFER: if (phase_end) begin
                cnt_d = '0;
                sck_d = !sck_q;
                if (!sck_q) shift_d = {shift_q[10:0], bus.adc_sdo};
                else begin
                    sdi_d = cfg_q[4];
                    cfg_d = {cfg_q[4:0], 1'b0};
                    bit_d = bit_q + 4'd1;
                end
            end
            DONE: begin
                data_out_d = shift_q;
                data_ch_d  = prev_ch_q;
                prev_ch_d  = cur_ch_q;
                valid_d    = 1'b1;
                busy_d     = 1'b0;
            end
            default: ;
        endcase
        if (launch) begin
            cfg_d    = {1'b1, bus.ch_sel[0], bus.ch_sel[2], bus.ch_sel[1], 2'b10};
            cur_ch_d = bus.ch_sel;
            busy_d   = 1'b1;
            convst_d = 1'b1;
            cnt_d    = '0;
        end
    end

    // datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            cfg_q      <= '0;
            cur_ch_q   <= '0;
            prev_ch_q  <= '0;
            data_ch_q  <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            convst_q   <= 1'b0;
            sck_q      <= 1'b0;
            sdi_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            cfg_q      <= cfg_d;
            cur_ch_q   <= cur_ch_d;
            prev_ch_q  <= prev_ch_d;
            data_ch_q  <= data_ch_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            convst_q   <= convst_d;
            sck_q      <= sck_d;
            sdi_q      <= sdi_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.adc_convst = convst_q;
    assign bus.adc_sck    = sck_q;
    assign bus.adc_sdi    = sdi_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_ch    = data_ch_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;

`ifdef ADC_SAMPLE_CNT_EN
    logic [15:0] sample_cnt_q, sample_cnt_d;

    // count delivered results, wrapping at 16 bits
    always_comb
        sample_cnt_d = valid_d ? sample_cnt_q + 16'd1 : sample_cnt_q;

    // sample counter register
    always_ff @(posedge clk)
        sample_cnt_q <= !reset_n ? 16'd0 : sample_cnt_d;

    assign bus.sample_cnt = sample_cnt_q;
`endif
endmodule

// File: tb/tb_ltc2308_sample_ctrl.sv
// tb_ltc2308_sample_ctrl: random/directed bench with an LTC2308 pin model and frame-level reference model
module tb_ltc2308_sample_ctrl;
    localparam int DIV0 = 2, CNV0 = 80, DIV1 = 1, CNV1 = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = !clk;

    ltc2308_sample_ctrl_if ifa ();
    ltc2308_sample_ctrl_if ifb ();

    ltc2308_sample_ctrl #(.CLK_DIV(DIV0), .CONV_CYCLES(CNV0)) u_dut (.clk(clk), .reset_n(reset_n), .bus(ifa));
    ltc2308_sample_ctrl #(.CLK_DIV(DIV1), .CONV_CYCLES(CNV1)) u_fast (.clk(clk), .reset_n(reset_n), .bus(ifb));

    logic [1:0]  sdo = 2'b00;
    logic [1:0]  convst, sck, sdi, dv, busy, cont;
    logic [11:0] dout [2];
    logic [2:0]  dch [2], chs [2];

    assign ifa.adc_sdo = sdo[0];
    assign ifb.adc_sdo = sdo[1];
    assign convst = {ifb.adc_convst, ifa.adc_convst};
    assign sck    = {ifb.adc_sck, ifa.adc_sck};
    assign sdi    = {ifb.adc_sdi, ifa.adc_sdi};
    assign dv     = {ifb.data_valid, ifa.data_valid};
    assign busy   = {ifb.busy, ifa.busy};
    assign cont   = {ifb.continuous, ifa.continuous};
    assign dout[0] = ifa.data_out;
    assign dout[1] = ifb.data_out;
    assign dch[0]  = ifa.data_ch;
    assign dch[1]  = ifb.data_ch;
    assign chs[0]  = ifa.ch_sel;
    assign chs[1]  = ifb.ch_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // config word the ADC must receive for a channel (single-ended, unipolar, awake)
    function automatic logic [5:0] cfg_of(input logic [2:0] c);
        return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
    endfunction

    function automatic int frame_len(input int k);
        return k == 0 ? CNV0 + 24 * DIV0 + 1 : CNV1 + 24 * DIV1 + 1;
    endfunction

    // reference model state per instance
    logic [11:0] word_m [2], next_word [2], sh [2], held [2], sdi_m [2];
    logic [2:0]  cur_m [2], prev_m [2];
    int          t0 [2], last_dv [2], rises [2], hi [2], dv_cnt [2];
    bit          active [2], chained [2];
    logic [1:0]  convst_p = 2'b00, sck_p = 2'b00;
    bit          live = 1'b0;
    int          tick = 0;

    // pin model and scoreboard, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        tick++;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                check("rst_sck", sck[k], 0);
                check("rst_convst", convst[k], 0);
                check("rst_busy", busy[k], 0);
                check("rst_valid", dv[k], 0);
                check("rst_dout", dout[k], 0);
                check("rst_dch", dch[k], 0);
                active[k] = 0;
                prev_m[k] = 0;
                held[k]   = 0;
                live      = 1'b1;
            end else begin
                if (live && !dv[k]) check("hold", dout[k], held[k]);
                if (dv[k]) begin
                    dv_cnt[k]++;
                    check("dv_in_frame", active[k], 1);
                    check("data", dout[k], word_m[k]);
                    check("data_ch", dch[k], prev_m[k]);
                    check("sdi_bits", sdi_m[k], {cfg_of(cur_m[k]), 6'b0});
                    check("sck_rises", rises[k], 12);
                    check("latency", tick - t0[k] + 1, frame_len(k) + 1);
                    if (chained[k]) check("period", tick - last_dv[k], frame_len(k));
                    check("busy_done", busy[k], cont[k]);
                    prev_m[k]  = cur_m[k];
                    held[k]    = word_m[k];
                    active[k]  = 0;
                    last_dv[k] = tick;
                end else if (active[k]) check("busy", busy[k], 1);
                if (convst[k] && !convst_p[k]) begin
                    check("no_restart", active[k], 0);
                    chained[k]   = dv[k];
                    active[k]    = 1;
                    t0[k]        = tick;
                    cur_m[k]     = chs[k];
                    word_m[k]    = next_word[k];
                    next_word[k] = 12'($urandom);
                    sh[k]        = word_m[k];
                    sdo[k]       = sh[k][11];
                    rises[k]     = 0;
                    sdi_m[k]     = 0;
                    hi[k]        = 1;
                end else if (convst[k]) hi[k]++;
                if (!convst[k] && convst_p[k]) check("convst_width", hi[k], 2);
                if (sck[k] && !sck_p[k]) begin
                    rises[k]++;
                    sdi_m[k] = {sdi_m[k][10:0], sdi[k]};
                end
                if (!sck[k] && sck_p[k]) begin
                    sh[k]  = {sh[k][10:0], 1'b0};
                    sdo[k] = sh[k][11];
                end
            end
        end
        convst_p = convst;
        sck_p    = sck;
    end

    task automatic pulse_start(input int k, input logic [2:0] ch);
        if (k == 0) begin ifa.ch_sel = ch; ifa.start = 1'b1; end
        else begin ifb.ch_sel = ch; ifb.start = 1'b1; end
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    task automatic wait_dv(input int k, input int budget);
        int c0 = dv_cnt[k];
        for (int i = 0; i < budget && dv_cnt[k] == c0; i++) @(negedge clk);
        check("dv_timeout", 32'(dv_cnt[k] != c0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c;
        logic [15:0] exp_cnt;
        for (int k = 0; k < 2; k++) begin
            next_word[k] = 0;
            dv_cnt[k]    = 0;
            rises[k]     = 0;
        end
        ifa.start = 0; ifa.continuous = 0; ifa.ch_sel = 0;
        ifb.start = 0; ifb.continuous = 0; ifb.ch_sel = 0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        next_word[0] = 12'hA5C;
        pulse_start(0, 3'd5);
        wait_dv(0, 300);
        check("t1_data", ifa.data_out, 12'hA5C);
        check("t1_ch", ifa.data_ch, 3'd0);
        check("t1_sdi", sdi_m[0][11:6], 6'b111010);
        repeat (3) @(negedge clk);

        next_word[0] = 12'h123;
        pulse_start(0, 3'd2);
        wait_dv(0, 300);
        check("t2_data", ifa.data_out, 12'h123);
        check("t2_ch", ifa.data_ch, 3'd5);
        check("t2_sdi", sdi_m[0][11:6], 6'b100110);

        c = dv_cnt[0];
        pulse_start(0, 3'd6);
        repeat (39) @(negedge clk);
        pulse_start(0, 3'd7);
        check("t3_busy", ifa.busy, 1);
        wait_dv(0, 300);
        repeat (150) @(negedge clk);
        check("t3_one_dv", dv_cnt[0] - c, 1);
        check("t3_idle", ifa.busy, 0);

        for (int i = 0; i < 5; i++) begin
            next_word[0] = 12'($urandom);
            pulse_start(0, 3'($urandom_range(0, 7)));
            wait_dv(0, 300);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        ifb.continuous = 1'b1;
        pulse_start(1, 3'd3);
        for (int i = 0; i < 5; i++) begin
            wait_dv(1, 80);
            repeat ($urandom_range(1, 20)) @(negedge clk);
            ifb.ch_sel = 3'($urandom_range(0, 7));
        end
        wait_dv(1, 80);
        repeat (15) @(negedge clk);
        ifb.continuous = 1'b0;
        wait_dv(1, 80);
        c = dv_cnt[1];
        repeat (60) @(negedge clk);
        check("cont_stop", dv_cnt[1], c);
        check("cont_idle", ifb.busy, 0);

        pulse_start(0, 3'd4);
        for (int i = 0; i < 400 && rises[0] < 5; i++) @(negedge clk);
        check("rise5", rises[0], 5);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        c = dv_cnt[0];
        repeat (150) @(negedge clk);
        check("rst_no_dv", dv_cnt[0], c);
        next_word[0] = 12'h5A3;
        pulse_start(0, 3'd1);
        wait_dv(0, 300);
        check("rst_after_data", ifa.data_out, 12'h5A3);
        check("rst_after_ch", ifa.data_ch, 3'd0);

`ifdef ADC_SAMPLE_CNT_EN
        force u_dut.sample_cnt_q = 16'hFFFE;
        @(negedge clk);
        release u_dut.sample_cnt_q;
        exp_cnt = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            pulse_start(0, 3'($urandom_range(0, 7)));
            wait_dv(0, 300);
            check("sample_cnt", ifa.sample_cnt, exp_cnt);
            exp_cnt = exp_cnt + 16'd1;
        end
`else
        exp_cnt = 16'd0;
`endif
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
